// File: rtl/seq_divider.sv
// Sequential restoring divider: one quotient bit per clock, MSB first.
// Optional macro SEQ_DIVIDER_DBZ_DETECT_EN short-cuts divide-by-zero in one edge and drives dbz.
module seq_divider #(
  parameter int width = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [width-1:0] a,
  input  logic [width-1:0] b,
  output logic [width-1:0] q,
  output logic [width-1:0] r,
  output logic             busy,
  output logic             done,
  output logic             dbz
);

  localparam int CW = $clog2(width + 1);

  typedef enum logic {IDLE, CALC} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [width-1:0] dividend_q, dividend_d;
  logic [width-1:0] divisor_q, divisor_d;
  logic [width:0]   rem_q, rem_d;
  logic [width-1:0] quo_q, quo_d;
  logic [width-1:0] res_q, res_d;
  logic             done_q, done_d;

  // The dividend register doubles as the quotient collector: bits leave at
  // the top while quotient bits enter at the bottom.
  logic [width+1:0] shifted;
  logic [width:0]   remSub;
  logic             fits;

  assign shifted = {rem_q, dividend_q[width-1]};
  assign fits    = (shifted >= {2'b00, divisor_q});
  assign remSub  = shifted[width:0] - {1'b0, divisor_q};

`ifdef SEQ_DIVIDER_DBZ_DETECT_EN
  logic dbz_q, dbz_d;
`endif

  always_comb begin
    logic [width:0]   remNext;
    logic [width-1:0] dividendNext;
    state_d    = state_q;
    cnt_d      = cnt_q;
    dividend_d = dividend_q;
    divisor_d  = divisor_q;
    rem_d      = rem_q;
    quo_d      = quo_q;
    res_d      = res_q;
    done_d     = 1'b0;
    remNext      = fits ? remSub : shifted[width:0];
    dividendNext = {dividend_q[width-2:0], fits};
`ifdef SEQ_DIVIDER_DBZ_DETECT_EN
    dbz_d = dbz_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
`ifdef SEQ_DIVIDER_DBZ_DETECT_EN
          if (b == '0) begin
            quo_d  = '1;
            res_d  = a;
            dbz_d  = 1'b1;
            done_d = 1'b1;
          end else begin
            dividend_d = a;
            divisor_d  = b;
            rem_d      = '0;
            cnt_d      = CW'(width);
            state_d    = CALC;
          end
`else
          dividend_d = a;
          divisor_d  = b;
          rem_d      = '0;
          cnt_d      = CW'(width);
          state_d    = CALC;
`endif
        end
      end
      CALC: begin
        rem_d      = remNext;
        dividend_d = dividendNext;
        cnt_d      = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          quo_d   = dividendNext;
          res_d   = remNext[width-1:0];
          done_d  = 1'b1;
          state_d = IDLE;
`ifdef SEQ_DIVIDER_DBZ_DETECT_EN
          dbz_d   = 1'b0;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      dividend_q <= '0;
      divisor_q  <= '0;
      rem_q      <= '0;
      quo_q      <= '0;
      res_q      <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      dividend_q <= dividend_d;
      divisor_q  <= divisor_d;
      rem_q      <= rem_d;
      quo_q      <= quo_d;
      res_q      <= res_d;
      done_q     <= done_d;
    end
  end

`ifdef SEQ_DIVIDER_DBZ_DETECT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) dbz_q <= 1'b0;
    else     dbz_q <= dbz_d;
  end
  assign dbz = dbz_q;
`else
  assign dbz = 1'b0;
`endif

  assign q    = quo_q;
  assign r    = res_q;
  assign busy = (state_q == CALC);
  assign done = done_q;

endmodule
